// File: rtl/cpu19_pkg.sv
// Shared CPU19 types and constants: datapath widths, LSU state encoding and op codes.
package cpu19_pkg;

    localparam int DATA_W        = 19;
    localparam int ADDR_W        = 19;
    localparam int LSU_MEM_DEPTH = 512;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } lsu_state_t;

    localparam logic LSU_OP_LOAD  = 1'b0;
    localparam logic LSU_OP_STORE = 1'b1;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response channel plus data-memory pins of the load/store unit.
interface load_store_unit_if;
    import cpu19_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    // Execute stage: issues requests and consumes responses.
    modport master (
        output req_valid, req_store, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Load/store unit: serves requests and drives the data memory.
    modport slave (
        input  req_valid, req_store, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_write, mem_read
    );

    modport mem (
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );

endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time to a synchronous data memory with one-cycle read latency.
//  state   | meaning
//  IDLE    | ready to accept a request
//  ACCESS  | single-cycle read or write strobe to memory
//  CAPTURE | read data returning from memory is registered
//  RESP    | response held until the consumer takes it
module load_store_unit
    import cpu19_pkg::*;
#(
    parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    lsu_state_t        state_q;
    lsu_state_t        state_d;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              out_of_range;

    assign accept       = (state_q == IDLE) && bus.req_valid;
    assign out_of_range = bus.req_addr >= ADDR_W'(MEM_DEPTH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = out_of_range ? RESP : ACCESS;
            ACCESS:  state_d = (op_q == LSU_OP_STORE) ? RESP : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= LSU_OP_LOAD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= bus.req_store;
                rdata_q <= '0;
                err_q   <= out_of_range;
                // Rejected requests leave the memory address/data pins untouched.
                if (!out_of_range) begin
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                end
            end
            if (state_q == CAPTURE) rdata_q <= bus.mem_rdata;
            if (state_q == RESP && bus.resp_ready) err_q <= 1'b0;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_write  = (state_q == ACCESS) && (op_q == LSU_OP_STORE);
    assign bus.mem_read   = (state_q == ACCESS) && (op_q == LSU_OP_LOAD);

endmodule
